// File: rtl/serial_eval_pkg.sv
// Shared definitions for the serial evaluation slice (sample store and
// sample player).
//   state_t             : player sequencing states
//   SEQ_LEN             : serial steps per stored entry
//   NUM_SAMPLES_DEFAULT : highest entry index shared with the sample store
package serial_eval_pkg;

  localparam int SEQ_LEN             = 8;
  localparam int NUM_SAMPLES_DEFAULT = 24;

  typedef enum logic [2:0] {
    IDLE,
    CUT,
    DRIVE,
    SETTLE,
    COMPARE,
    DONE
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times the idle gap between stepping the
// evolved circuit and sampling its output.
//   iClock, iReset : clock, asynchronous active-high reset
//   iLoad          : preload with SETTLE_CYCLES-1 (the first SETTLE cycle
//                    sees this value)
//   iCount         : decrement by one, stopping at zero
//   oZero          : counter is zero, meaning the current SETTLE cycle is
//                    the last one
module settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic iClock,
  input  logic iReset,
  input  logic iLoad,
  input  logic iCount,
  output logic oZero
);

  // Loading SETTLE_CYCLES-1 makes the count reach zero on the last of
  // exactly SETTLE_CYCLES wait cycles.
  localparam logic [3:0] LOAD_VALUE =
    (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  logic [3:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      count <= '0;
    end else if (iLoad) begin
      count <= LOAD_VALUE;
    end else if (iCount && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign oZero = (count == '0);

endmodule

// File: rtl/serial_sample_player.sv
// Plays every stored 8-bit input sequence, LSB first, into the evolved serial
// circuit and scores the circuit's output against the expected bits wherever
// the valid mask is set. The score and error counts are the fitness result.
//   iClock, iReset    : clock, asynchronous active-high reset
//   iStart            : request a full evaluation (taken only in IDLE)
//   iInputSequences   : serial stimulus per entry, bit 0 played first
//   iExpectedOutputs  : expected circuit output per step
//   iValidOutputs     : 1 = step is scored
//   oCircuitReset     : one-cycle clear of circuit state before each entry
//   oCircuitInput     : stimulus bit, stable from DRIVE through COMPARE
//   oCircuitStep      : one-cycle clock enable to the circuit
//   iCircuitOutput    : circuit output, sampled in COMPARE
//   oBusy, oDone      : run in progress / one-cycle completion pulse
//   oScore, oErrors   : saturating matched / mismatched scored steps
//   oEntryIndex       : entry being played (debug)
module serial_sample_player
  import serial_eval_pkg::*;
#(
  parameter int NUM_SAMPLES   = NUM_SAMPLES_DEFAULT,
  parameter int SETTLE_CYCLES = 1,
  parameter int SCORE_W       = 16
) (
  input  logic                         iClock,
  input  logic                         iReset,
  input  logic                         iStart,
  input  logic [NUM_SAMPLES:0][7:0]    iInputSequences,
  input  logic [NUM_SAMPLES:0][7:0]    iExpectedOutputs,
  input  logic [NUM_SAMPLES:0][7:0]    iValidOutputs,
  output logic                         oCircuitReset,
  output logic                         oCircuitInput,
  output logic                         oCircuitStep,
  input  logic                         iCircuitOutput,
  output logic                         oBusy,
  output logic                         oDone,
  output logic [SCORE_W-1:0]           oScore,
  output logic [SCORE_W-1:0]           oErrors,
  output logic [7:0]                   oEntryIndex
);

  localparam int IDX_W  = (NUM_SAMPLES > 0) ? $clog2(NUM_SAMPLES + 1) : 1;
  localparam int STEP_W = $clog2(SEQ_LEN);
  localparam logic [IDX_W-1:0]  LAST_ENTRY = IDX_W'(NUM_SAMPLES);
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(SEQ_LEN - 1);

  state_t              state, next_state;
  logic [IDX_W-1:0]    entry;
  logic [STEP_W-1:0]   step;
  logic [SCORE_W-1:0]  score, errors;
  logic                settle_zero;
  logic                cur_input, cur_expected, cur_valid;

  // Arrays are read live; the controller holds them stable while busy.
  assign cur_input    = iInputSequences[entry][step];
  assign cur_expected = iExpectedOutputs[entry][step];
  assign cur_valid    = iValidOutputs[entry][step];

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_settle_timer (
    .iClock (iClock),
    .iReset (iReset),
    .iLoad  (state == DRIVE),
    .iCount (state == SETTLE),
    .oZero  (settle_zero)
  );

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (iStart) next_state = CUT;
      CUT:     next_state = DRIVE;
      DRIVE:   next_state = (SETTLE_CYCLES > 0) ? SETTLE : COMPARE;
      SETTLE:  if (settle_zero) next_state = COMPARE;
      COMPARE: begin
        if (step != LAST_STEP)       next_state = DRIVE;
        else if (entry != LAST_ENTRY) next_state = CUT;
        else                          next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      entry  <= '0;
      step   <= '0;
      score  <= '0;
      errors <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            entry  <= '0;
            score  <= '0;
            errors <= '0;
          end
        end
        CUT: step <= '0;
        COMPARE: begin
          if (cur_valid) begin
            if (iCircuitOutput == cur_expected) score  <= sat_inc(score);
            else                                errors <= sat_inc(errors);
          end
          if (step != LAST_STEP)        step  <= step + 1'b1;
          else if (entry != LAST_ENTRY) entry <= entry + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign oCircuitReset = (state == CUT);
  assign oCircuitStep  = (state == DRIVE);
  assign oCircuitInput = cur_input &&
                         ((state == DRIVE) || (state == SETTLE) || (state == COMPARE));
  assign oBusy         = (state != IDLE);
  assign oDone         = (state == DONE);
  assign oScore        = score;
  assign oErrors       = errors;
  assign oEntryIndex   = 8'(entry);

endmodule
